multiplier_core: RTL

Iterative shift-add multiplier datapath behind the `multiplier_v1_0` AXI4-Lite register slave. The slave writes operands from `slv_reg0`/`slv_reg1` and a start bit from `slv_reg2`, then reads the 64-bit product back into its read-data mux. The core computes one radix-2 partial product per cycle and reports completion with a busy/done handshake. It trades latency for area: one adder of width `DATA_WIDTH`, no DSP inference.

---
 rtl/multiplier_pkg.sv | 14 +
 rtl/multiplier_core.sv | 116 +++++++++++
 2 files changed

// File: rtl/multiplier_pkg.sv
// Shared types for the shift-add multiplier and its AXI4-Lite slave.
package multiplier_pkg;

  localparam int MULT_DATA_WIDTH = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } mult_state_e;

  typedef logic [2*MULT_DATA_WIDTH-1:0] mult_prod_t;

endpackage

// File: rtl/multiplier_core.sv
// Iterative radix-2 shift-add multiplier, one partial product per cycle.
// Signed operand support is built only with MULTIPLIER_CORE_SIGNED_EN.
module multiplier_core
  import multiplier_pkg::*;
#(
  parameter int DATA_WIDTH = MULT_DATA_WIDTH
) (
  input  logic                    ACLK,
  input  logic                    ARESET,
  input  logic                    start,
  input  logic [DATA_WIDTH-1:0]   op_a,
  input  logic [DATA_WIDTH-1:0]   op_b,
  input  logic                    signed_mode,
  output logic                    busy,
  output logic                    done,
  output logic [2*DATA_WIDTH-1:0] result,
  output logic                    result_valid
);

  localparam int W  = DATA_WIDTH;
  localparam int CW = (W > 1) ? $clog2(W) : 1;

  mult_state_e    r_state;
  logic [2*W-1:0] r_acc;
  logic [2*W-1:0] r_result;
  logic [W-1:0]   r_mcand;
  logic [W-1:0]   r_mplier;
  logic [CW-1:0]  r_cnt;
  logic           r_done;
  logic           r_valid;

  logic [W-1:0]   w_addend;
  logic [W:0]     w_sum;
  logic [2*W-1:0] w_acc_nxt;
  logic [2*W-1:0] w_final;
  logic [W-1:0]   w_mag_a;
  logic [W-1:0]   w_mag_b;

  // Carry out of the upper-half add becomes the new MSB after the shift.
  assign w_addend  = r_mplier[0] ? r_mcand : {W{1'b0}};
  assign w_sum     = {1'b0, r_acc[2*W-1:W]} + {1'b0, w_addend};
  assign w_acc_nxt = {w_sum, r_acc[W-1:1]};

`ifdef MULTIPLIER_CORE_SIGNED_EN
  logic w_neg_a;
  logic w_neg_b;
  logic r_neg;

  assign w_neg_a = signed_mode & op_a[W-1];
  assign w_neg_b = signed_mode & op_b[W-1];
  assign w_mag_a = w_neg_a ? -op_a : op_a;
  assign w_mag_b = w_neg_b ? -op_b : op_b;
  assign w_final = r_neg ? -w_acc_nxt : w_acc_nxt;

  always_ff @(posedge ACLK) begin
    if (ARESET)
      r_neg <= 1'b0;
    else if (r_state == IDLE && start)
      r_neg <= w_neg_a ^ w_neg_b;
  end
`else
  logic w_unused_signed;

  assign w_unused_signed = signed_mode;
  assign w_mag_a         = op_a;
  assign w_mag_b         = op_b;
  assign w_final         = w_acc_nxt;
`endif

  // The product is committed on the last RUN edge so it is visible with done.
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      r_state  <= IDLE;
      r_acc    <= '0;
      r_result <= '0;
      r_mcand  <= '0;
      r_mplier <= '0;
      r_cnt    <= '0;
      r_done   <= 1'b0;
      r_valid  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      unique case (r_state)
        IDLE: begin
          if (start) begin
            r_mcand  <= w_mag_a;
            r_mplier <= w_mag_b;
            r_acc    <= '0;
            r_cnt    <= CW'(W - 1);
            r_valid  <= 1'b0;
            r_state  <= RUN;
          end
        end
        RUN: begin
          r_acc    <= w_acc_nxt;
          r_mplier <= r_mplier >> 1;
          r_cnt    <= r_cnt - 1'b1;
          if (r_cnt == '0) begin
            r_result <= w_final;
            r_done   <= 1'b1;
            r_valid  <= 1'b1;
            r_state  <= DONE;
          end
        end
        DONE: r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

  assign busy         = (r_state == RUN);
  assign done         = r_done;
  assign result       = r_result;
  assign result_valid = r_valid;

endmodule
